ifetch_stage: RTL and testbench
===============================

# ifetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 32-bit pipelined CPU. It holds the program counter and fetches one 32-bit word per request from instruction memory over a req/ack handshake. It presents `{pco, inst, valid}` directly to the decode stage. It honours a hazard-unit stall and a branch/jump redirect that flushes the wrong-path instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INST`, default 32'h0000_0000: instruction word driven on `inst` when `valid`=0.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `stall`  in  1: hazard unit; 1 = hold IF/ID outputs and PC.
- `redirect`  in  1: taken branch/jump from execute; flush and load `redirect_pc`.
- `redirect_pc`  in  32: target address.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: word address of the request, registered.
- `imem_ack`  in  1: read data valid this cycle; completes the current request.
- `imem_rdata`  in  32: instruction word.
- `pco`  out  32: address of `inst`, to decode `pci`.
- `inst`  out  32: fetched instruction, to decode `inst`.
- `valid`  out  1: `inst` is a real instruction (0 = bubble).

## Operation
- Word-addressed PC: sequential next address = `imem_addr` + 1, mod 2^32 (32'hFFFF_FFFF wraps to 0).
- Internal registers:
  - `imem_addr`
  - `pc_next`: address of the next request
  - `drop`: discard the response of the outstanding request
  - `buf_inst` and `buf_pc`: one-entry hold buffer
  - state
- States:
  - FETCH: `imem_req`=1.
  - HOLD: `imem_req`=0; a word is parked in the buffer.
- FETCH, no ack:
  - If `stall`=0, IF/ID loads a bubble (`valid`=0, `inst`=`NOP_INST`, `pco` unchanged).
  - If `stall`=1, IF/ID holds.
- FETCH, ack, `drop`=1: discard `imem_rdata` and clear `drop`. `imem_addr` <= `pc_next`, so the new request appears the next cycle. IF/ID follows the no-ack rule.
- FETCH, ack, `drop`=0, `stall`=0: IF/ID <= {`imem_addr`, `imem_rdata`, 1}. `imem_addr` <= `imem_addr`+1. Stay in FETCH.
- FETCH, ack, `drop`=0, `stall`=1: buffer <= {`imem_addr`, `imem_rdata`}. `imem_addr` <= `imem_addr`+1. Go to HOLD. IF/ID holds.
- HOLD, `stall`=0: IF/ID <= {`buf_pc`, `buf_inst`, 1}. Go to FETCH.
- HOLD, `stall`=1: no change.
- Redirect has highest priority and overrides `stall` and ack:
  - IF/ID is flushed: `valid`<=0, `inst`<=`NOP_INST`, `pco`<=`redirect_pc`.
  - The buffer is discarded and the next state is FETCH.
  - If in FETCH with no ack this cycle: `imem_addr` is held (the request must complete), `drop`<=1, `pc_next`<=`redirect_pc`.
  - If in FETCH with ack this cycle: `rdata` is discarded and `imem_addr`<=`redirect_pc` with no drop.
  - If in HOLD: `imem_addr`<=`redirect_pc`.
  - A second redirect while `drop`=1 only overwrites `pc_next`.
- `imem_addr` never changes while `imem_req`=1 and `imem_ack`=0.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `imem_req`=0 (forced low while in reset)
  - `imem_addr`=`RESET_PC`, `pc_next`=`RESET_PC`
  - `pco`=`RESET_PC`, `inst`=`NOP_INST`, `valid`=0
  - `drop`=0, state=FETCH, buffer cleared
- `imem_req` is combinational from state and `rst_n`. It rises as soon as `rst_n` is deasserted.
- Same-cycle ack (zero-wait memory) gives 1 instruction/cycle; the word is visible on `inst` at the edge after the ack.
- An N-cycle memory inserts N-1 bubbles per instruction.
- Redirect asserted at edge k: the wrong-path `valid` is 0 after edge k. With zero-wait memory, the target word has `valid`=1 after edge k+1.
- Reset mid-transaction abandons the outstanding request. Memory must tolerate `imem_req` dropping without an ack.
- `stall` and `redirect` are sampled only on rising `clk`.

## Test plan
- Reset release with always-ack memory returning `addr`+32'hA000: `pco`/`inst` = 0/A000, 1/A001, 2/A002 on consecutive cycles with `valid`=1.
- Memory with 2-cycle ack latency: `valid` pattern 0,1,0,1; `imem_addr` stable across each wait cycle.
- `stall` held 3 cycles while ack arrives for addr 5: IF/ID holds the addr-4 word, `imem_req`=0 in HOLD. After the stall releases, `pco`=5, and the next request is addr 6.
- Redirect to 32'h40 while a 3-cycle request to addr 8 is pending: the addr-8 data is dropped, `valid`=0. The next request is 32'h40 and `pco`=40 appears with `valid`=1.
- Redirect and `stall` together in HOLD: flush wins, the buffer is discarded, and `imem_addr`=`redirect_pc` the next cycle.
- Start at `RESET_PC`=32'hFFFF_FFFE: addresses go FFFF_FFFE, FFFF_FFFF, 0000_0000. Assert `rst_n`=0 mid-request: all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_stage.sv
// ifetch_stage: program counter, instruction-memory req/ack fetch and the
// IF/ID pipeline register for the 32-bit pipelined CPU.
// A one-entry hold buffer parks a word that arrives while decode is stalled,
// so the outstanding request can always complete. A redirect flushes IF/ID and
// steers the fetch. If a request is still in flight, its response is
// dropped first.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pco,
  output logic [31:0] inst,
  output logic        valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] pc_next_reg;
  logic        drop_reg;
  logic [31:0] buf_inst_reg;
  logic [31:0] buf_pc_reg;
  logic [31:0] pco_reg;
  logic [31:0] inst_reg;
  logic        valid_reg;

  logic [31:0] addr_inc;

  // Sequential word address; wraps naturally at 2^32.
  assign addr_inc = addr_reg + 32'd1;

  // Request is driven from state, but forced low while reset is held.
  assign imem_req = rst_n && (state_reg == FETCH);

  assign imem_addr = addr_reg;
  assign pco       = pco_reg;
  assign inst      = inst_reg;
  assign valid     = valid_reg;

  // Fetch FSM, hold buffer and IF/ID register. Redirect takes precedence over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      addr_reg     <= RESET_PC;
      pc_next_reg  <= RESET_PC;
      drop_reg     <= 1'b0;
      buf_inst_reg <= 32'h0;
      buf_pc_reg   <= 32'h0;
      pco_reg      <= RESET_PC;
      inst_reg     <= NOP_INST;
      valid_reg    <= 1'b0;
    end else if (redirect) begin
      // Flush the wrong-path instruction and discard any parked word.
      valid_reg    <= 1'b0;
      inst_reg     <= NOP_INST;
      pco_reg      <= redirect_pc;
      buf_inst_reg <= 32'h0;
      buf_pc_reg   <= 32'h0;
      state_reg    <= FETCH;
      if (state_reg == FETCH) begin
        if (imem_ack) begin
          // The request completes now, so its data is simply ignored.
          addr_reg <= redirect_pc;
          drop_reg <= 1'b0;
        end else begin
          // The request is still in flight and the address must stay put.
          // Remember the target and drop the eventual response.
          drop_reg    <= 1'b1;
          pc_next_reg <= redirect_pc;
        end
      end else begin
        addr_reg <= redirect_pc;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ack && drop_reg) begin
            // Wrong-path response: discard it and launch the redirect target.
            drop_reg <= 1'b0;
            addr_reg <= pc_next_reg;
            if (!stall) begin
              valid_reg <= 1'b0;
              inst_reg  <= NOP_INST;
            end
          end else if (imem_ack) begin
            addr_reg <= addr_inc;
            if (!stall) begin
              pco_reg   <= addr_reg;
              inst_reg  <= imem_rdata;
              valid_reg <= 1'b1;
            end else begin
              // Decode is stalled. Park the word so the request can still retire.
              buf_pc_reg   <= addr_reg;
              buf_inst_reg <= imem_rdata;
              state_reg    <= HOLD;
            end
          end else if (!stall) begin
            // Waiting on memory: feed decode a bubble.
            valid_reg <= 1'b0;
            inst_reg  <= NOP_INST;
          end
        end
        HOLD: begin
          if (!stall) begin
            pco_reg   <= buf_pc_reg;
            inst_reg  <= buf_inst_reg;
            valid_reg <= 1'b1;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed testbench for ifetch_stage. It has a variable-latency memory model
// whose data is addr + 32'hA000. A second instance uses a high RESET_PC to cover
// address wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_ifetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pco;
  logic [31:0] inst;
  logic        valid;

  logic        rst_n2;
  logic        stall2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic [31:0] pco2;
  logic [31:0] inst2;
  logic        valid2;

  int lat;
  int wait_cnt;
  int errors;
  int checks;

  ifetch_stage u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pco         (pco),
    .inst        (inst),
    .valid       (valid)
  );

  ifetch_stage #(
    .RESET_PC (32'hFFFF_FFFE),
    .NOP_INST (32'hDEAD_BEEF)
  ) u_dut_hi (
    .clk         (clk),
    .rst_n       (rst_n2),
    .stall       (stall2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .imem_req    (imem_req2),
    .imem_addr   (imem_addr2),
    .imem_ack    (imem_ack2),
    .imem_rdata  (imem_rdata2),
    .pco         (pco2),
    .inst        (inst2),
    .valid       (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after 'lat' cycles of continuous request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= 0;
    else if (imem_req && imem_ack) wait_cnt <= 0;
    else if (imem_req)             wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end
  assign imem_ack    = imem_req && (wait_cnt >= lat - 1);
  assign imem_rdata  = imem_addr + 32'h0000_A000;

  // Zero-wait memory for the second instance
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2 + 32'h0000_A000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                          input logic e_valid);
    check({tag, ".pco"},   pco,   e_pc);
    check({tag, ".inst"},  inst,  e_inst);
    check({tag, ".valid"}, {31'h0, valid}, {31'h0, e_valid});
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    lat          = 1;
    rst_n        = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    rst_n2       = 1'b0;
    stall2       = 1'b0;
    redirect2    = 1'b0;
    redirect_pc2 = 32'h0;

    // Reset state
    tick();
    check("rst.req",  {31'h0, imem_req}, 32'h0);
    check("rst.addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst2.inst", inst2, 32'hDEAD_BEEF);
    tick();
    rst_n = 1'b1;
    #1;
    check("rel.req",  {31'h0, imem_req}, 32'h1);
    check("rel.addr", imem_addr, 32'h0);

    // Zero-wait memory, one instruction per cycle
    tick(); chk_ifid("zw0", 32'h0, 32'hA000, 1'b1);
    tick(); chk_ifid("zw1", 32'h1, 32'hA001, 1'b1);
    tick(); chk_ifid("zw2", 32'h2, 32'hA002, 1'b1);
    check("zw.addr", imem_addr, 32'h3);

    // Two-cycle memory: valid 0,1,0,1 and a stable address while waiting
    lat = 2;
    tick(); check("l2a.valid", {31'h0, valid}, 32'h0); check("l2a.addr", imem_addr, 32'h3);
            check("l2a.pco", pco, 32'h2);
    tick(); chk_ifid("l2b", 32'h3, 32'hA003, 1'b1);
    tick(); check("l2c.valid", {31'h0, valid}, 32'h0); check("l2c.addr", imem_addr, 32'h4);
    tick(); chk_ifid("l2d", 32'h4, 32'hA004, 1'b1);

    // Stall for 3 cycles while the addr-5 word arrives
    lat = 1;
    stall = 1'b1;
    tick(); chk_ifid("st0", 32'h4, 32'hA004, 1'b1);
            check("st0.req", {31'h0, imem_req}, 32'h0); check("st0.addr", imem_addr, 32'h6);
    tick(); chk_ifid("st1", 32'h4, 32'hA004, 1'b1); check("st1.req", {31'h0, imem_req}, 32'h0);
    tick(); chk_ifid("st2", 32'h4, 32'hA004, 1'b1);
    stall = 1'b0;
    tick(); chk_ifid("st3", 32'h5, 32'hA005, 1'b1);
            check("st3.req", {31'h0, imem_req}, 32'h1); check("st3.addr", imem_addr, 32'h6);
    tick(); chk_ifid("st4", 32'h6, 32'hA006, 1'b1);
    tick(); chk_ifid("st5", 32'h7, 32'hA007, 1'b1);

    // Redirect to 0x40 while a 3-cycle request to addr 8 is pending
    lat = 3;
    tick(); check("rd0.valid", {31'h0, valid}, 32'h0); check("rd0.addr", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    #1;
    chk_ifid("rd1", 32'h40, 32'h0, 1'b0);
    check("rd1.addr", imem_addr, 32'h8);
    lat = 1;
    tick(); chk_ifid("rd2", 32'h40, 32'h0, 1'b0); check("rd2.addr", imem_addr, 32'h40);
    tick(); chk_ifid("rd3", 32'h40, 32'hA040, 1'b1);

    // Redirect together with stall while in HOLD
    stall = 1'b1;
    tick(); check("rh0.req", {31'h0, imem_req}, 32'h0); check("rh0.addr", imem_addr, 32'h42);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0; stall = 1'b0;
    #1;
    chk_ifid("rh1", 32'h80, 32'h0, 1'b0);
    check("rh1.addr", imem_addr, 32'h80); check("rh1.req", {31'h0, imem_req}, 32'h1);
    tick(); chk_ifid("rh2", 32'h80, 32'hA080, 1'b1);

    // Redirect on a cycle with an ack: target word valid one edge later
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #1;
    chk_ifid("ra0", 32'h100, 32'h0, 1'b0);
    check("ra0.addr", imem_addr, 32'h100);
    tick(); chk_ifid("ra1", 32'h100, 32'hA100, 1'b1);

    // High RESET_PC: address wrap, then asynchronous reset mid-request
    check("hi.rst.pco", pco2, 32'hFFFF_FFFE);
    check("hi.rst.req", {31'h0, imem_req2}, 32'h0);
    rst_n2 = 1'b1;
    #1;
    check("hi.rel.addr", imem_addr2, 32'hFFFF_FFFE);
    tick(); check("hi0.pco", pco2, 32'hFFFF_FFFE); check("hi0.inst", inst2, 32'h0000_9FFE);
            check("hi0.addr", imem_addr2, 32'hFFFF_FFFF);
    tick(); check("hi1.pco", pco2, 32'hFFFF_FFFF); check("hi1.inst", inst2, 32'h0000_9FFF);
            check("hi1.addr", imem_addr2, 32'h0);
    tick(); check("hi2.pco", pco2, 32'h0); check("hi2.inst", inst2, 32'h0000_A000);
            check("hi2.valid", {31'h0, valid2}, 32'h1);
    rst_n2 = 1'b0;
    #1;
    check("ar.req",   {31'h0, imem_req2}, 32'h0);
    check("ar.addr",  imem_addr2, 32'hFFFF_FFFE);
    check("ar.pco",   pco2, 32'hFFFF_FFFE);
    check("ar.inst",  inst2, 32'hDEAD_BEEF);
    check("ar.valid", {31'h0, valid2}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
